// File: rtl/dsha_nonce_sched_if.sv
// Signal bundle of the double-SHA nonce scheduler: job intake, SHA core link,
// found-result handshake and job status.
interface dsha_nonce_sched_if;
  logic         job_valid;
  logic         job_ready;
  logic [255:0] midstate;
  logic [95:0]  tail;
  logic [31:0]  nonce_start;
  logic [31:0]  nonce_end;
  logic [255:0] target;
  logic         stop;
  logic         sha_start;
  logic [255:0] sha_iv;
  logic [511:0] sha_block;
  logic         sha_ready;
  logic [255:0] sha_digest;
  logic         sha_digest_valid;
  logic         found_valid;
  logic [31:0]  found_nonce;
  logic [255:0] found_hash;
  logic         found_ready;
  logic         busy;
  logic         done;
  logic         aborted;

  modport master (
    output job_valid, midstate, tail, nonce_start, nonce_end, target, stop,
           sha_ready, sha_digest, sha_digest_valid, found_ready,
    input  job_ready, sha_start, sha_iv, sha_block, found_valid, found_nonce,
           found_hash, busy, done, aborted
  );

  modport slave (
    input  job_valid, midstate, tail, nonce_start, nonce_end, target, stop,
           sha_ready, sha_digest, sha_digest_valid, found_ready,
    output job_ready, sha_start, sha_iv, sha_block, found_valid, found_nonce,
           found_hash, busy, done, aborted
  );
endinterface

// File: rtl/dsha_nonce_sched.sv
// Walks a nonce range through an external SHA-256 compression core, running the
// second block of the header hash and then the outer hash, and reports target hits.
module dsha_nonce_sched (
  input  logic              clk,
  input  logic              rst_n,
  dsha_nonce_sched_if.slave bus
);
  localparam logic [255:0] SHA_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  typedef enum logic [2:0] {IDLE, H1_ST, H1_WT, H2_ST, H2_WT, REPORT} state_t;

  state_t       state_reg;
  logic [255:0] midstate_reg;
  logic [255:0] target_reg;
  logic [95:0]  tail_reg;
  logic [31:0]  nonce_cur_reg;
  logic [31:0]  nonce_end_reg;
  logic         stop_pending_reg;
  logic         job_ready_reg;
  logic         busy_reg;
  logic         sha_start_reg;
  logic         found_valid_reg;
  logic         done_reg;
  logic         aborted_reg;
  logic [255:0] sha_iv_reg;
  logic [511:0] sha_block_reg;
  logic [31:0]  found_nonce_reg;
  logic [255:0] found_hash_reg;

  logic [255:0] digest_bswap;
  logic [31:0]  nonce_inc;
  logic         stop_now;
  logic         hit;
  logic         range_end;
  logic         do_abort;
  logic         do_advance;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [511:0] h1_block(input logic [95:0] t, input logic [31:0] n);
    return {t, bswap32(n), 32'h80000000, 320'h0, 32'h00000280};
  endfunction

  function automatic logic [511:0] h2_block(input logic [255:0] d);
    return {d, 32'h80000000, 192'h0, 32'h00000100};
  endfunction

  // The digest is big-endian words; the hit test compares it as a little-endian number.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_bswap
      assign digest_bswap[8*gi +: 8] = bus.sha_digest[255-8*gi -: 8];
    end
  endgenerate

  assign stop_now  = stop_pending_reg | bus.stop;
  assign hit       = (digest_bswap <= target_reg);
  assign range_end = (nonce_cur_reg == nonce_end_reg);
  assign nonce_inc = nonce_cur_reg + 32'd1;

  always_comb begin
    do_abort   = 1'b0;
    do_advance = 1'b0;
    case (state_reg)
      H1_ST, H2_ST: do_abort = stop_now & ~bus.sha_ready;
      H1_WT:        do_abort = stop_now & bus.sha_digest_valid;
      H2_WT: begin
        if (bus.sha_digest_valid) begin
          do_abort   = stop_now;
          do_advance = ~stop_now & ~hit;
        end
      end
      REPORT: begin
        if (bus.found_ready) begin
          do_abort   = stop_now;
          do_advance = ~stop_now;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      midstate_reg     <= '0;
      target_reg       <= '0;
      tail_reg         <= '0;
      nonce_cur_reg    <= '0;
      nonce_end_reg    <= '0;
      stop_pending_reg <= 1'b0;
      job_ready_reg    <= 1'b1;
      busy_reg         <= 1'b0;
      sha_start_reg    <= 1'b0;
      found_valid_reg  <= 1'b0;
      done_reg         <= 1'b0;
      aborted_reg      <= 1'b0;
      sha_iv_reg       <= '0;
      sha_block_reg    <= '0;
      found_nonce_reg  <= '0;
      found_hash_reg   <= '0;
    end else begin
      done_reg <= 1'b0;
      if (busy_reg && bus.stop)
        stop_pending_reg <= 1'b1;

      if (do_abort || (do_advance && range_end)) begin
        state_reg        <= IDLE;
        sha_start_reg    <= 1'b0;
        found_valid_reg  <= 1'b0;
        job_ready_reg    <= 1'b1;
        busy_reg         <= 1'b0;
        done_reg         <= 1'b1;
        aborted_reg      <= do_abort;
        stop_pending_reg <= 1'b0;
      end else if (do_advance) begin
        state_reg       <= H1_ST;
        nonce_cur_reg   <= nonce_inc;
        sha_start_reg   <= 1'b1;
        sha_iv_reg      <= midstate_reg;
        sha_block_reg   <= h1_block(tail_reg, nonce_inc);
        found_valid_reg <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (bus.job_valid) begin
              state_reg        <= H1_ST;
              midstate_reg     <= bus.midstate;
              target_reg       <= bus.target;
              tail_reg         <= bus.tail;
              nonce_cur_reg    <= bus.nonce_start;
              nonce_end_reg    <= bus.nonce_end;
              stop_pending_reg <= 1'b0;
              job_ready_reg    <= 1'b0;
              busy_reg         <= 1'b1;
              aborted_reg      <= 1'b0;
              sha_start_reg    <= 1'b1;
              sha_iv_reg       <= bus.midstate;
              sha_block_reg    <= h1_block(bus.tail, bus.nonce_start);
            end
          end
          H1_ST, H2_ST: begin
            if (bus.sha_ready) begin
              sha_start_reg <= 1'b0;
              state_reg     <= (state_reg == H1_ST) ? H1_WT : H2_WT;
            end
          end
          H1_WT: begin
            if (bus.sha_digest_valid) begin
              state_reg     <= H2_ST;
              sha_start_reg <= 1'b1;
              sha_iv_reg    <= SHA_IV;
              sha_block_reg <= h2_block(bus.sha_digest);
            end
          end
          H2_WT: begin
            // Reaching here with a digest means a hit; misses and stops advance above.
            if (bus.sha_digest_valid) begin
              state_reg       <= REPORT;
              found_valid_reg <= 1'b1;
              found_nonce_reg <= nonce_cur_reg;
              found_hash_reg  <= bus.sha_digest;
            end
          end
          REPORT: ;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign bus.job_ready   = job_ready_reg;
  assign bus.busy        = busy_reg;
  assign bus.sha_start   = sha_start_reg;
  assign bus.sha_iv      = sha_iv_reg;
  assign bus.sha_block   = sha_block_reg;
  assign bus.found_valid = found_valid_reg;
  assign bus.found_nonce = found_nonce_reg;
  assign bus.found_hash  = found_hash_reg;
  assign bus.done        = done_reg;
  assign bus.aborted     = aborted_reg;
endmodule

// File: tb/tb_dsha_nonce_sched.sv
// Directed bench for dsha_nonce_sched; a behavioural SHA-256 compression core
// answers the scheduler with a fixed latency.
module tb_dsha_nonce_sched;
  localparam logic [255:0] SHA_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [511:0] GEN_HDR0 = {32'h01000000, 256'h0, 32'h3ba3edfd, 32'h7a7b12b2,
    32'h7ac72c3e, 32'h67768f61, 32'h7fc81bc3, 32'h888a5132, 32'h3a9fb8aa};
  localparam logic [95:0]  GEN_TAIL = 96'h4b1e5e4a_29ab5f49_ffff001d;
  localparam logic [255:0] GEN_HASH = 256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;
  localparam logic [255:0] MS_A = 256'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0;
  localparam logic [95:0]  TAIL_B = 96'hdeadbeef_cafef00d_00112233;
  localparam int CORE_LAT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dsha_nonce_sched_if bus ();
  dsha_nonce_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0]  acc_nonce[$];
  logic [31:0]  found_n[$];
  logic [255:0] found_h[$];

  logic         core_ready = 1'b1;
  logic         core_valid = 1'b0;
  logic [255:0] core_digest = '0;
  logic [255:0] core_iv = '0;
  logic [511:0] core_blk = '0;
  int           core_cnt = 0;
  assign bus.sha_ready        = core_ready;
  assign bus.sha_digest_valid = core_valid;
  assign bus.sha_digest       = core_digest;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [255:0] bswap256(input logic [255:0] x);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = x[255-8*i -: 8];
    return r;
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] iv, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-7]
           + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
    {a, b, c, d, e, f, g, h} = iv;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {iv[255:224] + a, iv[223:192] + b, iv[191:160] + c, iv[159:128] + d,
            iv[127:96] + e, iv[95:64] + f, iv[63:32] + g, iv[31:0] + h};
  endfunction

  // Core model: accepts on sha_start && ready, answers CORE_LAT cycles later.
  always @(posedge clk) begin
    core_valid <= 1'b0;
    if (core_ready && bus.sha_start) begin
      core_iv    <= bus.sha_iv;
      core_blk   <= bus.sha_block;
      core_ready <= 1'b0;
      core_cnt   <= CORE_LAT;
      acc_nonce.push_back(bswap32(bus.sha_block[415:384]));
    end else if (!core_ready) begin
      if (core_cnt == 1) begin
        core_digest <= sha_compress(core_iv, core_blk);
        core_valid  <= 1'b1;
        core_ready  <= 1'b1;
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  task automatic clear_logs();
    acc_nonce.delete();
    found_n.delete();
    found_h.delete();
  endtask

  task automatic start_job(input logic [255:0] ms, input logic [95:0] tl,
                           input logic [31:0] ns, input logic [31:0] ne, input logic [255:0] tg);
    @(negedge clk);
    bus.midstate    = ms;
    bus.tail        = tl;
    bus.nonce_start = ns;
    bus.nonce_end   = ne;
    bus.target      = tg;
    bus.job_valid   = 1'b1;
    @(negedge clk);
    bus.job_valid   = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output logic got, output logic ab);
    got = 1'b0;
    ab  = 1'b0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      @(negedge clk);
      if (bus.found_valid && bus.found_ready) begin
        found_n.push_back(bus.found_nonce);
        found_h.push_back(bus.found_hash);
      end
      if (bus.done) begin
        got = 1'b1;
        ab  = bus.aborted;
      end
    end
    $display("job end: done=%0b aborted=%0b accepts=%0d founds=%0d", got, ab, acc_nonce.size(), found_n.size());
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.job_ready, bus.busy, bus.sha_start, bus.found_valid, bus.done, bus.aborted} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 100000", {bus.job_ready, bus.busy, bus.sha_start,
               bus.found_valid, bus.done, bus.aborted});
    end
    n_cmp++;
    if ({bus.found_nonce, bus.found_hash} !== 288'h0) begin
      n_fail++; $display("FAIL reset_found: nonce %h hash %h want 0", bus.found_nonce, bus.found_hash);
    end
    n_cmp++;
    if ({bus.sha_iv, bus.sha_block} !== 768'h0) begin
      n_fail++; $display("FAIL reset_sha: iv %h want 0", bus.sha_iv);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.job_ready, bus.busy} !== 2'b10) begin
      n_fail++; $display("FAIL reset_release: ready/busy %b want 10", {bus.job_ready, bus.busy});
    end
  endtask

  task automatic test_genesis();
    logic got, ab;
    logic [255:0] ms, tg, h0;
    logic [31:0] n0;
    clear_logs();
    ms = sha_compress(SHA_IV, GEN_HDR0);
    tg = 256'h0000ffff;
    tg = tg << 208;
    start_job(ms, GEN_TAIL, 32'h7c2bac1b, 32'h7c2bac1e, tg);
    n_cmp++;
    if ({bus.sha_start, bus.busy, bus.job_ready} !== 3'b110) begin
      n_fail++; $display("FAIL gen_first_start: start/busy/ready %b want 110", {bus.sha_start, bus.busy, bus.job_ready});
    end
    n_cmp++;
    if (bus.sha_iv !== ms) begin
      n_fail++; $display("FAIL gen_iv: got %h want %h", bus.sha_iv, ms);
    end
    n_cmp++;
    if (bus.sha_block !== {GEN_TAIL, 32'h1bac2b7c, 32'h80000000, 320'h0, 32'h00000280}) begin
      n_fail++; $display("FAIL gen_block: got %h", bus.sha_block);
    end
    wait_done(400, got, ab);
    n_cmp++;
    if ({got, ab} !== 2'b10) begin
      n_fail++; $display("FAIL gen_done: done/aborted %b want 10", {got, ab});
    end
    n_cmp++;
    if (found_n.size() != 1) begin
      n_fail++; $display("FAIL gen_found_count: got %0d want 1", found_n.size());
    end
    n0 = (found_n.size() > 0) ? found_n[0] : 32'h0;
    h0 = (found_h.size() > 0) ? found_h[0] : 256'h0;
    n_cmp++;
    if (n0 !== 32'h7c2bac1d) begin
      n_fail++; $display("FAIL gen_nonce: got %h want 7c2bac1d", n0);
    end
    n_cmp++;
    if (bswap256(h0) !== GEN_HASH) begin
      n_fail++; $display("FAIL gen_hash: got %h want %h", bswap256(h0), GEN_HASH);
    end
    n_cmp++;
    if (acc_nonce.size() != 8) begin
      n_fail++; $display("FAIL gen_accepts: got %0d want 8", acc_nonce.size());
    end
  endtask

  task automatic test_miss();
    logic got, ab;
    logic [63:0] pair;
    clear_logs();
    start_job(MS_A, TAIL_B, 32'd0, 32'd2, 256'h0);
    wait_done(300, got, ab);
    n_cmp++;
    if ({got, ab, found_n.size() == 0} !== 3'b101) begin
      n_fail++; $display("FAIL miss_done: done/aborted %b%b founds %0d want 10 and 0", got, ab, found_n.size());
    end
    n_cmp++;
    if (acc_nonce.size() != 6) begin
      n_fail++; $display("FAIL miss_accepts: got %0d want 6", acc_nonce.size());
    end
    clear_logs();
    start_job(MS_A, TAIL_B, 32'd5, 32'd6, '1);
    wait_done(300, got, ab);
    pair = (found_n.size() == 2) ? {found_n[0], found_n[1]} : 64'h0;
    n_cmp++;
    if (pair !== {32'd5, 32'd6}) begin
      n_fail++; $display("FAIL hit_nonces: got %h (count %0d) want 00000005_00000006", pair, found_n.size());
    end
    n_cmp++;
    if ({got, ab} !== 2'b10 || acc_nonce.size() != 4) begin
      n_fail++; $display("FAIL hit_done: done/aborted %b%b accepts %0d want 10 and 4", got, ab, acc_nonce.size());
    end
  endtask

  task automatic test_wrap();
    logic got, ab;
    logic [127:0] seq;
    clear_logs();
    start_job(MS_A, TAIL_B, 32'hfffffffe, 32'h00000001, 256'h0);
    wait_done(400, got, ab);
    n_cmp++;
    if (acc_nonce.size() != 8 || {got, ab} !== 2'b10) begin
      n_fail++; $display("FAIL wrap_accepts: got %0d done/aborted %b%b want 8 and 10", acc_nonce.size(), got, ab);
    end
    seq = (acc_nonce.size() == 8) ? {acc_nonce[0], acc_nonce[2], acc_nonce[4], acc_nonce[6]} : 128'h0;
    n_cmp++;
    if (seq !== 128'hfffffffe_ffffffff_00000000_00000001) begin
      n_fail++; $display("FAIL wrap_order: got %h", seq);
    end
  endtask

  task automatic test_backpressure();
    logic got, ab, bad, seen;
    logic [31:0] hold_n;
    logic [255:0] hold_h, d1, exp_h;
    int acc_before;
    clear_logs();
    bus.found_ready = 1'b0;
    d1    = sha_compress(MS_A, {TAIL_B, 32'h0a000000, 32'h80000000, 320'h0, 32'h00000280});
    exp_h = sha_compress(SHA_IV, {d1, 32'h80000000, 192'h0, 32'h00000100});
    start_job(MS_A, TAIL_B, 32'd10, 32'd11, '1);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = bus.found_valid;
    end
    hold_n = bus.found_nonce;
    hold_h = bus.found_hash;
    n_cmp++;
    if ({seen, hold_n} !== {1'b1, 32'd10}) begin
      n_fail++; $display("FAIL bp_found: seen %b nonce %h want 1 and 0000000a", seen, hold_n);
    end
    n_cmp++;
    if (hold_h !== exp_h) begin
      n_fail++; $display("FAIL bp_hash: got %h want %h", hold_h, exp_h);
    end
    acc_before = acc_nonce.size();
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (!bus.found_valid || bus.found_nonce !== hold_n || bus.found_hash !== hold_h || bus.sha_start)
        bad = 1'b1;
    end
    n_cmp++;
    if (bad || acc_nonce.size() != acc_before) begin
      n_fail++; $display("FAIL bp_hold: unstable %b accepts %0d want 0 and %0d", bad, acc_nonce.size(), acc_before);
    end
    bus.found_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.found_valid, bus.sha_start} !== 2'b01) begin
      n_fail++; $display("FAIL bp_advance: valid/start %b want 01", {bus.found_valid, bus.sha_start});
    end
    wait_done(200, got, ab);
    n_cmp++;
    if (found_n.size() != 1 || {got, ab} !== 2'b10 || (found_n.size() == 1 && found_n[0] !== 32'd11)) begin
      n_fail++; $display("FAIL bp_second: founds %0d done/aborted %b%b want nonce 0000000b", found_n.size(), got, ab);
    end
  endtask

  task automatic test_stop_h1wt();
    logic ab;
    int v_at, d_at;
    clear_logs();
    start_job(MS_A, TAIL_B, 32'd100, 32'd200, 256'h0);
    for (int i = 0; i < 50 && acc_nonce.size() < 1; i++) @(negedge clk);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    v_at = -1;
    d_at = -1;
    ab   = 1'b0;
    for (int i = 0; i < 50 && d_at < 0; i++) begin
      @(negedge clk);
      if (bus.sha_digest_valid && v_at < 0) v_at = i;
      if (bus.done) begin
        d_at = i;
        ab   = bus.aborted;
      end
    end
    $display("stop job: digest at %0d done at %0d aborted=%0b", v_at, d_at, ab);
    n_cmp++;
    if (v_at < 0 || d_at != v_at + 1) begin
      n_fail++; $display("FAIL stop_timing: done at %0d want %0d", d_at, v_at + 1);
    end
    n_cmp++;
    if (ab !== 1'b1 || acc_nonce.size() != 1) begin
      n_fail++; $display("FAIL stop_abort: aborted %b accepts %0d want 1 and 1", ab, acc_nonce.size());
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.job_ready, bus.aborted, bus.busy, bus.done} !== 4'b1100) begin
      n_fail++; $display("FAIL stop_idle: ready/aborted/busy/done %b want 1100",
                         {bus.job_ready, bus.aborted, bus.busy, bus.done});
    end
  endtask

  task automatic test_reset_h2wt();
    logic got, ab, bad;
    clear_logs();
    start_job(MS_A, TAIL_B, 32'd300, 32'd301, 256'h0);
    for (int i = 0; i < 50 && acc_nonce.size() < 2; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.job_ready, bus.busy, bus.sha_start, bus.found_valid, bus.done, bus.aborted} !== 6'b100000) begin
      n_fail++; $display("FAIL rst_mid_flags: got %b want 100000", {bus.job_ready, bus.busy, bus.sha_start,
               bus.found_valid, bus.done, bus.aborted});
    end
    n_cmp++;
    if ({bus.sha_iv, bus.sha_block, bus.found_nonce, bus.found_hash} !== 1056'h0) begin
      n_fail++; $display("FAIL rst_mid_data: iv %h nonce %h want 0", bus.sha_iv, bus.found_nonce);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.busy || bus.done || bus.found_valid || bus.sha_start || !bus.job_ready) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_fail++; $display("FAIL rst_stray_digest: activity %b want 0", bad);
    end
    clear_logs();
    start_job(MS_A, TAIL_B, 32'h12345678, 32'h12345678, 256'h0);
    n_cmp++;
    if (bus.sha_block !== {TAIL_B, 32'h78563412, 32'h80000000, 320'h0, 32'h00000280}) begin
      n_fail++; $display("FAIL rst_new_block: got %h", bus.sha_block);
    end
    wait_done(200, got, ab);
    n_cmp++;
    if ({got, ab} !== 2'b10 || acc_nonce.size() != 2 || (acc_nonce.size() > 0 && acc_nonce[0] !== 32'h12345678)) begin
      n_fail++; $display("FAIL rst_new_job: done/aborted %b%b accepts %0d want 10 and 2", got, ab, acc_nonce.size());
    end
  endtask

  initial begin
    bus.job_valid   = 1'b0;
    bus.midstate    = '0;
    bus.tail        = '0;
    bus.nonce_start = '0;
    bus.nonce_end   = '0;
    bus.target      = '0;
    bus.stop        = 1'b0;
    bus.found_ready = 1'b1;
    test_reset();
    test_genesis();
    test_miss();
    test_wrap();
    test_backpressure();
    test_stop_h1wt();
    test_reset_h2wt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end
endmodule
